register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/register_file_mp.sv | 123 ++++++++++++
 tb/tb_register_file_mp.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multi-ported register file.
package rf_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_NUM_READ   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set by reservations, cleared by committed writes or a bulk clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEFAULT_NUM_READ
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic                           clr_en,
    input  logic [ADDR_WIDTH-1:0]          clr_addr,
    input  logic                           clear_all,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ-1:0]            pending
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Set is applied after clear so a same-edge reserve wins over the write.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
        if (clear_all) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            pending[k] = pend_q[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write bypass, reservation scoreboard and
// a sequential bulk-clear engine that zeroes one register per cycle.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEFAULT_NUM_READ
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           read_enable,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
    output logic [NUM_READ-1:0]            pending,
    input  logic                           write_enable,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           reserve_valid,
    input  logic [ADDR_WIDTH-1:0]          reserve_addr,
    input  logic                           clear_req,
    output logic                           clear_busy,
    output logic                           clear_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    rf_state_e             state;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic idle;
    logic wr_commit;
    logic rsv_commit;
    logic clear_start;

    // Qualifying with reset keeps the bypass path quiet on an edge that ignores the write.
    assign idle        = (state == StIdle);
    assign wr_commit   = idle && !reset && write_enable && (write_addr != '0);
    assign rsv_commit  = idle && !reset && reserve_valid && (reserve_addr != '0);
    assign clear_start = idle && !reset && clear_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            clear_idx  <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (clear_req) begin
                        state      <= StClear;
                        clear_idx  <= ADDR_WIDTH'(1);
                        clear_busy <= 1'b1;
                    end
                end
                StClear: begin
                    if (clear_idx == LAST_IDX) begin
                        state      <= StDone;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clear_idx <= clear_idx + ADDR_WIDTH'(1);
                    end
                end
                StDone: begin
                    state      <= StIdle;
                    clear_done <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[write_addr] <= write_data;
        end else if (state == StClear) begin
            regs[clear_idx] <= '0;
        end
    end

    always_comb begin
        data_out = '0;
        rd_addr  = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_addr = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (read_enable && (rd_addr != '0)) begin
                if (wr_commit && (write_addr == rd_addr)) begin
                    data_out[k*DATA_WIDTH +: DATA_WIDTH] = write_data;
                end else begin
                    data_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (rsv_commit),
        .set_addr  (reserve_addr),
        .clr_en    (wr_commit),
        .clr_addr  (write_addr),
        .clear_all (clear_start),
        .read_addr (read_addr),
        .pending   (pending)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with a behavioural model checked every cycle.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_enable = 1'b0;
    logic [9:0]  read_addr = '0;
    logic [63:0] data_out;
    logic [1:0]  pending;
    logic        write_enable = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [31:0] write_data = '0;
    logic        reserve_valid = 1'b0;
    logic [4:0]  reserve_addr = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        clear_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register contents, pending flags and clear progress.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_busy;
    bit          m_done;
    int          m_next;

    register_file_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_READ   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_enable   (read_enable),
        .read_addr     (read_addr),
        .data_out      (data_out),
        .pending       (pending),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .clear_req     (clear_req),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        m_next = 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge reset) model_reset();

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else if (m_busy) begin
            m_regs[m_next] = '0;
            if (m_next == 31) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_next++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            if (write_enable && write_addr != 0) begin
                m_regs[write_addr] = write_data;
                m_pend[write_addr] = 1'b0;
            end
            if (reserve_valid && reserve_addr != 0) m_pend[reserve_addr] = 1'b1;
            if (clear_req) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
                m_busy = 1'b1;
                m_next = 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [4:0]  a;
        logic [31:0] e;
        for (int k = 0; k < 2; k++) begin
            a = read_addr[k*5 +: 5];
            if (!read_enable || a == 0) e = '0;
            else if (!m_busy && !m_done && !reset && write_enable && write_addr == a) e = write_data;
            else e = m_regs[a];
            check($sformatf("model_data_out[%0d] addr %0d", k, a),
                  64'(data_out[k*32 +: 32]), 64'(e));
            check($sformatf("model_pending[%0d] addr %0d", k, a), 64'(pending[k]), 64'(m_pend[a]));
        end
        check("model_clear_busy", 64'(clear_busy), 64'(m_busy));
        check("model_clear_done", 64'(clear_done), 64'(m_done));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        model_reset();
        repeat (2) tick();
        #2;
        check("reset_clear_busy", 64'(clear_busy), 64'(0));
        check("reset_clear_done", 64'(clear_done), 64'(0));
        check("reset_pending", 64'(pending), 64'(0));
        tick();
        reset = 1'b0;

        // Load reg i with i
        for (int i = 0; i < 32; i++) begin
            write_enable = 1'b1;
            write_addr   = 5'(i);
            write_data   = 32'(i);
            tick();
        end
        write_enable = 1'b0;
        read_enable  = 1'b1;
        read_addr    = {5'd30, 5'd1};
        #2;
        check("read_30_1", data_out, {32'd30, 32'd1});
        tick();
        read_addr = '0;
        #2;
        check("read_addr0", data_out, 64'(0));
        tick();

        // Same-cycle bypass
        write_enable = 1'b1;
        write_addr   = 5'd7;
        write_data   = 32'hDEADBEEF;
        read_addr    = {5'd0, 5'd7};
        #2;
        check("bypass_7", 64'(data_out[31:0]), 64'(32'hDEADBEEF));
        tick();
        write_enable = 1'b0;
        #2;
        check("stored_7", 64'(data_out[31:0]), 64'(32'hDEADBEEF));
        tick();

        // Reservation scoreboard
        reserve_valid = 1'b1;
        reserve_addr  = 5'd5;
        read_addr     = {5'd0, 5'd5};
        #2;
        check("pend_before_reserve", 64'(pending[0]), 64'(0));
        tick();
        reserve_valid = 1'b0;
        #2;
        check("pend_after_reserve", 64'(pending[0]), 64'(1));
        tick();
        read_enable = 1'b0;
        #2;
        check("pend_ignores_read_enable", 64'(pending[0]), 64'(1));
        tick();
        read_enable  = 1'b1;
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'h55;
        tick();
        write_enable = 1'b0;
        #2;
        check("pend_cleared_by_write", 64'(pending[0]), 64'(0));
        tick();
        write_enable  = 1'b1;
        write_data    = 32'h66;
        reserve_valid = 1'b1;
        tick();
        write_enable  = 1'b0;
        reserve_valid = 1'b0;
        #2;
        check("pend_reserve_wins", 64'(pending[0]), 64'(1));
        check("data_reserve_write", 64'(data_out[31:0]), 64'(32'h66));
        tick();
        reserve_valid = 1'b1;
        reserve_addr  = 5'd0;
        read_addr     = '0;
        tick();
        reserve_valid = 1'b0;
        #2;
        check("pend_reg0", 64'(pending[0]), 64'(0));
        tick();

        // Bulk clear with a write attempted mid-clear
        read_addr = {5'd31, 5'd3};
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (i == 5) begin
                #1;
                write_enable = 1'b1;
                write_addr   = 5'd3;
                write_data   = 32'h1234;
            end
            if (i == 6) begin
                #1;
                write_enable = 1'b0;
            end
        end
        check("clear_busy_cycles", 64'(busy_cnt), 64'(31));
        check("clear_done_pulses", 64'(done_cnt), 64'(1));
        tick();
        for (int a = 0; a < 32; a++) begin
            read_addr = {5'(a), 5'(a)};
            #2;
            if (a == 3 || a == 7 || a == 31) begin
                check($sformatf("cleared_reg_%0d", a), data_out, 64'(0));
            end
            tick();
        end
        read_addr = {5'd0, 5'd5};
        #2;
        check("pend5_after_clear", 64'(pending[0]), 64'(0));
        tick();

        // read_enable gating
        write_enable = 1'b1;
        write_addr   = 5'd9;
        write_data   = 32'hA5A5A5A5;
        tick();
        write_addr   = 5'd10;
        write_data   = 32'h5A5A5A5A;
        tick();
        write_addr   = 5'd20;
        write_data   = 32'h77;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        read_addr    = {5'd10, 5'd9};
        #2;
        check("read_enable_low", data_out, 64'(0));
        tick();
        read_enable = 1'b1;
        #2;
        check("read_enable_high", data_out, {32'h5A5A5A5A, 32'hA5A5A5A5});
        tick();

        // Reset ten cycles into a clear
        reserve_valid = 1'b1;
        reserve_addr  = 5'd12;
        tick();
        reserve_valid = 1'b0;
        clear_req     = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("busy_drops_on_reset", 64'(clear_busy), 64'(0));
        write_enable = 1'b1;
        write_addr   = 5'd4;
        write_data   = 32'h44;
        tick();
        reset        = 1'b0;
        write_enable = 1'b0;
        done_cnt     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clear_done) done_cnt++;
        end
        check("no_done_after_abort", 64'(done_cnt), 64'(0));
        tick();
        read_addr = {5'd20, 5'd4};
        #2;
        check("regs_zero_after_reset", data_out, 64'(0));
        tick();
        read_addr = {5'd12, 5'd9};
        #2;
        check("pend12_after_reset", 64'(pending[1]), 64'(0));
        check("reg9_after_reset", 64'(data_out[31:0]), 64'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
